// File: rtl/cmp_sched.sv
// Round-robin scheduler that shares one subtract/compare unit between two requesters.
// Grant edge -> EXEC -> DONE: done pulses in the DONE cycle; reqs are ignored while busy.
module cmp_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       fun0,
  input  logic [2:0]       fun1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_fun,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  input  logic             cmp_bit,
  output logic             done0,
  output logic             done1,
  output logic             result,
  output logic [2:0]       flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_fun_q, alu_fun_d;
  logic             result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic             gnt_sel;

  // rr_q names the requester that wins a tie; it flips to the other side on every grant.
  always_comb begin
    gnt_sel   = (req0 && req1) ? rr_q : req1;
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    result_d  = result_q;
    flags_d   = flags_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d   = EXEC;
          gnt_d     = gnt_sel;
          rr_d      = ~gnt_sel;
          alu_a_d   = gnt_sel ? a1 : a0;
          alu_b_d   = gnt_sel ? b1 : b0;
          alu_fun_d = gnt_sel ? fun1 : fun0;
        end
      end
      EXEC: begin
        state_d  = DONE;
        result_d = cmp_bit;
        flags_d  = {alu_z, alu_v, alu_n};
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      result_q  <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_fun = alu_fun_q;
  assign result  = result_q;
  assign flags   = flags_q;
  assign busy    = (state_q != IDLE);
  assign done0   = (state_q == DONE) && !gnt_q;
  assign done1   = (state_q == DONE) && gnt_q;

endmodule

// File: tb/tb_cmp_sched.sv
// Bench for cmp_sched: emulates the shared ALU/compare unit and checks against a timestamp-based reference.
module tb_cmp_sched;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   fun0, fun1;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_fun;
  logic         alu_z, alu_v, alu_n, cmp_bit;
  logic         done0, done1, result, busy;
  logic [2:0]   flags;

  cmp_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .fun0(fun0), .fun1(fun1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n), .cmp_bit(cmp_bit),
    .done0(done0), .done1(done1), .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment: subtract ALU flags and a compare unit decoding them.
  logic [W-1:0] alu_d;
  assign alu_d = alu_a - alu_b;
  assign alu_z = (alu_d == '0);
  assign alu_n = alu_d[W-1];
  assign alu_v = (alu_a[W-1] != alu_b[W-1]) && (alu_d[W-1] != alu_a[W-1]);
  always_comb begin
    cmp_bit = 1'b0;
    case (alu_fun)
      3'b001: cmp_bit = alu_z;
      3'b010: cmp_bit = alu_n ^ alu_v;
      3'b011: cmp_bit = ~(alu_n ^ alu_v);
      3'b100: cmp_bit = ~alu_z;
      3'b101: cmp_bit = ~(alu_n ^ alu_v) & ~alu_z;
      3'b110: cmp_bit = (alu_n ^ alu_v) | alu_z;
      default: cmp_bit = 1'b0;
    endcase
  end

  int n_chk = 0;
  int n_bad = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: operands compared as signed integers; flags from wide arithmetic.
  function automatic logic ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'b001:  return sa == sb;
      3'b010:  return sa <  sb;
      3'b011:  return sa >= sb;
      3'b100:  return sa != sb;
      3'b101:  return sa >  sb;
      3'b110:  return sa <= sb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sd;
    logic [W-1:0] d;
    logic v;
    sd = longint'($signed(a)) - longint'($signed(b));
    d  = a - b;
    v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {a == b, v, d[W-1]};
  endfunction

  // Model state: edge count and the edge of the most recent grant.
  int           edge_n = 0;
  int           g_edge = -10;
  bit           fav, m_who;
  logic         e_busy, e_d0, e_d1, e_res;
  logic [W-1:0] e_a, e_b;
  logic [2:0]   e_fun, e_flags;

  task automatic model_reset();
    g_edge = edge_n - 10;
    fav = 0; m_who = 0;
    e_busy = 0; e_d0 = 0; e_d1 = 0; e_res = 0;
    e_a = '0; e_b = '0; e_fun = '0; e_flags = '0;
  endtask

  // A grant occupies the edge it happens on plus two more; done is seen after the next edge.
  task automatic model_edge();
    bit who;
    if (!rst_n) return;
    edge_n++;
    if (edge_n >= g_edge + 3 && (req0 || req1)) begin
      who    = (req0 && req1) ? fav : req1;
      fav    = !who;
      m_who  = who;
      g_edge = edge_n;
      e_a    = who ? a1 : a0;
      e_b    = who ? b1 : b0;
      e_fun  = who ? fun1 : fun0;
    end
    e_busy = (edge_n - g_edge) <= 1;
    e_d0   = (edge_n == g_edge + 1) && !m_who;
    e_d1   = (edge_n == g_edge + 1) && m_who;
    if (edge_n == g_edge + 1) begin
      e_res   = ref_cmp(e_a, e_b, e_fun);
      e_flags = ref_flags(e_a, e_b);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, e_busy);
      chk("done0", done0, e_d0);
      chk("done1", done1, e_d1);
      chk("alu_a", alu_a, e_a);
      chk("alu_b", alu_b, e_b);
      chk("alu_fun", alu_fun, e_fun);
      chk("result", result, e_res);
      chk("flags", flags, e_flags);
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic go0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    req0 = 1; a0 = a; b0 = b; fun0 = f;
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    model_reset();
    #1;
    step();
    step();
    rst_n = 1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int seq_who[$];
  int seq_cyc[$];
  int pulses;

  initial begin
    rst_n = 0; req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; fun0 = '0; fun1 = '0;
    model_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_alu", {alu_fun, alu_b, alu_a}, 0);
    chk("rst_res", {flags, result}, 0);
    step(); step();
    rst_n = 1;
    chk_on = 1;

    // Equal operands, eq code: done0 seen after the second edge, z flag only.
    go0(5, 5, 3'b001);
    step();
    req0 = 0;
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_nodone", done0, 0);
    step();
    chk("t1_done0", {done1, done0}, 2'b01);
    chk("t1_result", result, 1);
    chk("t1_flags", flags, 3'b100);
    step();
    chk("t1_idle", {busy, done0}, 0);

    // Requester 1, signed less-than: 3-7 negative, no overflow.
    req1 = 1; a1 = 3; b1 = 7; fun1 = 3'b010;
    step();
    req1 = 0;
    step();
    chk("t2_done1", {done1, done0}, 2'b10);
    chk("t2_result", result, 1);
    chk("t2_flags", flags, 3'b001);
    step();

    // Simultaneous requests from reset alternate 0,1,0,1.
    pulse_reset();
    req0 = 1; req1 = 1; a0 = 10; b0 = 1; a1 = 1; b1 = 10; fun0 = 3'b101; fun1 = 3'b010;
    for (int i = 0; i < 13; i++) begin
      step();
      if (done0) begin seq_who.push_back(0); seq_cyc.push_back(i); end
      if (done1) begin seq_who.push_back(1); seq_cyc.push_back(i); end
    end
    req0 = 0; req1 = 0;
    chk("t3_count", seq_who.size(), 4);
    if (seq_who.size() >= 4) begin
      chk("t3_order", {seq_who[0][3:0], seq_who[1][3:0], seq_who[2][3:0], seq_who[3][3:0]}, 16'h0101);
      chk("t3_gap", seq_cyc[1] - seq_cyc[0], 3);
    end
    step(); step(); step();

    // Overflowing subtract with le-signed code: v set, result 0.
    go0(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b110);
    step();
    req0 = 0;
    step();
    chk("t4_done0", done0, 1);
    chk("t4_v", flags[1], 1);
    chk("t4_flags", flags, 3'b011);
    chk("t4_result", result, 0);
    step();

    // Reset during EXEC abandons the operation.
    go0(32'h1234, 32'h99, 3'b100);
    step();
    req0 = 0;
    chk("t5_exec", busy, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_outs", {done1, done0, result, flags, alu_fun}, 0);
    chk("t5_rst_alu", {alu_a, alu_b}, 0);
    step();
    chk("t5_nodone", {done1, done0}, 0);
    step();
    rst_n = 1;
    go0(9, 2, 3'b101);
    step();
    req0 = 0;
    step();
    chk("t5_after_done", done0, 1);
    chk("t5_after_res", result, 1);
    step();

    // req0 dropped during EXEC still completes with one pulse.
    go0(4, 8, 3'b011);
    step();
    req0 = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(done0);
    end
    chk("t6_pulses", pulses, 1);
    chk("t6_idle", busy, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      req0 = ($urandom_range(0, 9) < 4);
      req1 = ($urandom_range(0, 9) < 4);
      a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
      if ($urandom_range(0, 4) == 0) b0 = a0;
      if ($urandom_range(0, 4) == 0) b1 = a1;
      fun0 = 3'($urandom_range(0, 7));
      fun1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) pulse_reset();
      else step();
    end
    req0 = 0; req1 = 0;
    step(); step(); step();
    chk("end_idle", busy, 0);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
